vend_arbiter: RTL and testbench

VEND_ARBITER -- requirements
Module: vend_arbiter

---
 rtl/vend_arbiter.sv | 172 +++++++++++++++++
 tb/tb_vend_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vend_arbiter.sv
// Two-channel vending arbiter: round-robin grant of one dispenser, 5c/10c coin credit
// toward a 15c item, vend with change, refund on abort or coin-less timeout.
module vend_arbiter #(
  parameter int PRICE = 15,
  parameter int TMO   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] coin0,
  input  logic [1:0] coin1,
  input  logic       cancel0,
  input  logic       cancel1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       dispense,
  output logic [1:0] change,
  output logic       busy,
  output logic       coin_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_C0   = 3'd1,
    S_C5   = 3'd2,
    S_C10  = 3'd3,
    S_VEND = 3'd4,
    S_RET  = 3'd5
  } state_t;

  localparam logic [4:0] PRICE_C  = 5'(PRICE);
  localparam logic [3:0] TMO_LAST = 4'(TMO - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic       r_owner;
  logic       w_next_owner;
  logic       r_last_served;
  logic       w_next_last_served;
  logic [2:0] r_timer;
  logic [2:0] w_next_timer;
  logic [1:0] r_change;
  logic [1:0] w_next_change;
  logic       r_coin_err;
  logic       w_next_coin_err;

  logic [1:0] w_coin;
  logic       w_cancel;
  logic       w_req;
  logic       w_abort;
  logic       w_legal;
  logic       w_timeout;
  logic [4:0] w_credit;
  logic [4:0] w_coin_val;
  logic [4:0] w_sum;

  // Amount in cents to the 2-bit change code.
  function automatic logic [1:0] cents_code(input logic [4:0] cents);
    case (cents)
      5'd5:    cents_code = 2'b01;
      5'd10:   cents_code = 2'b10;
      default: cents_code = 2'b00;
    endcase
  endfunction

  // Credit state holding a sub-price amount.
  function automatic state_t credit_state(input logic [4:0] cents);
    case (cents)
      5'd5:    credit_state = S_C5;
      5'd10:   credit_state = S_C10;
      default: credit_state = S_C0;
    endcase
  endfunction

  // Only the owner's channel is ever looked at.
  assign w_coin     = r_owner ? coin1 : coin0;
  assign w_cancel   = r_owner ? cancel1 : cancel0;
  assign w_req      = r_owner ? req1 : req0;
  assign w_abort    = w_cancel | ~w_req;
  assign w_legal    = (w_coin == 2'b01) || (w_coin == 2'b10);
  assign w_timeout  = ({1'b0, r_timer} == TMO_LAST);
  assign w_credit   = (r_state == S_C5) ? 5'd5 : ((r_state == S_C10) ? 5'd10 : 5'd0);
  assign w_coin_val = (w_coin == 2'b01) ? 5'd5 : ((w_coin == 2'b10) ? 5'd10 : 5'd0);
  assign w_sum      = w_credit + w_coin_val;

  // Next-state, owner, timer and registered-output computation.
  always_comb begin
    w_next_state       = r_state;
    w_next_owner       = r_owner;
    w_next_last_served = r_last_served;
    w_next_timer       = r_timer;
    w_next_change      = 2'b00;
    w_next_coin_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_next_state = S_C0;
          w_next_timer = 3'd0;
          w_next_owner = (req0 && req1) ? ~r_last_served : req1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_C0, S_C5, S_C10: begin
        w_next_coin_err = (w_coin == 2'b11);
        if (w_legal) begin
          // The coin is applied before any abort is considered.
          w_next_timer = 3'd0;
          if (w_sum >= PRICE_C) begin
            w_next_state  = S_VEND;
            w_next_change = cents_code(w_sum - PRICE_C);
          end else if (w_abort) begin
            w_next_state  = S_RET;
            w_next_change = cents_code(w_sum);
          end else begin
            w_next_state = credit_state(w_sum);
          end
        end else begin
          w_next_timer = r_timer + 3'd1;
          if (w_abort || w_timeout) begin
            if (r_state == S_C0) begin
              w_next_state = S_IDLE;
              w_next_timer = 3'd0;
            end else begin
              w_next_state  = S_RET;
              w_next_change = cents_code(w_credit);
            end
          end else begin
            w_next_state = r_state;
          end
        end
      end
      S_VEND, S_RET: begin
        w_next_state       = S_IDLE;
        w_next_last_served = r_owner;
        w_next_timer       = 3'd0;
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_timer = 3'd0;
      end
    endcase
  end

  // State and output registers; reset drops any held credit without refund.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_owner       <= 1'b0;
      r_last_served <= 1'b1;
      r_timer       <= 3'd0;
      r_change      <= 2'b00;
      r_coin_err    <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_owner       <= w_next_owner;
      r_last_served <= w_next_last_served;
      r_timer       <= w_next_timer;
      r_change      <= w_next_change;
      r_coin_err    <= w_next_coin_err;
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign gnt0     = busy && (r_owner == 1'b0);
  assign gnt1     = busy && (r_owner == 1'b1);
  assign dispense = (r_state == S_VEND);
  assign change   = r_change;
  assign coin_err = r_coin_err;

endmodule

// File: tb/tb_vend_arbiter.sv
// Scoreboard bench for vend_arbiter: a cents-level session model predicts every
// cycle's outputs; a separate monitor pops and compares them.
module tb_vend_arbiter;

  localparam int PRICE = 15;
  localparam int TMO   = 8;

  typedef struct packed {
    logic       gnt0;
    logic       gnt1;
    logic       dispense;
    logic [1:0] change;
    logic       busy;
    logic       coin_err;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       req0, req1;
  logic [1:0] coin0, coin1;
  logic       cancel0, cancel1;
  logic       gnt0, gnt1, dispense, busy, coin_err;
  logic [1:0] change;

  exp_t q[$];
  logic imm_tgl;
  int   checks;
  int   errors;

  // Session model: busy flag, owner, credit in cents, coin-less cycle count,
  // and a pending end-of-session phase (0 none, 1 vend, 2 refund).
  int m_busy, m_owner, m_credit, m_idle, m_last, m_phase, m_chg;

  vend_arbiter #(.PRICE(PRICE), .TMO(TMO)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .coin0(coin0), .coin1(coin1),
    .cancel0(cancel0), .cancel1(cancel1),
    .gnt0(gnt0), .gnt1(gnt1),
    .dispense(dispense), .change(change),
    .busy(busy), .coin_err(coin_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares each predicted output set against the DUT.
  initial begin
    exp_t e;
    exp_t a;
    checks = 0;
    errors = 0;
    forever begin
      @(negedge clk or imm_tgl);
      while (q.size() > 0) begin
        e = q.pop_front();
        a = {gnt0, gnt1, dispense, change, busy, coin_err};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got gnt0=%b gnt1=%b disp=%b chg=%b busy=%b err=%b exp gnt0=%b gnt1=%b disp=%b chg=%b busy=%b err=%b",
                   $time, a.gnt0, a.gnt1, a.dispense, a.change, a.busy, a.coin_err,
                   e.gnt0, e.gnt1, e.dispense, e.change, e.busy, e.coin_err);
        end
        checks++;
        if (gnt0 && gnt1) begin
          errors++;
          $display("FAIL gnt_excl t=%0t got gnt0=%b gnt1=%b exp not both high", $time, gnt0, gnt1);
        end
      end
    end
  end

  task automatic m_reset();
    m_busy = 0; m_owner = 0; m_credit = 0; m_idle = 0;
    m_last = 1; m_phase = 0; m_chg = 0;
  endtask

  task automatic m_update(input logic r0, input logic r1, input logic [1:0] c0,
                          input logic [1:0] c1, input logic x0, input logic x1,
                          output exp_t e);
    int coin, val, err, abort_s;
    err = 0;
    if (m_phase != 0) begin
      m_busy = 0; m_last = m_owner; m_phase = 0; m_chg = 0; m_credit = 0;
    end else if (m_busy == 0) begin
      if (r0 || r1) begin
        m_owner  = (r0 && r1) ? (1 - m_last) : (r0 ? 0 : 1);
        m_busy   = 1;
        m_credit = 0;
        m_idle   = 0;
      end
    end else begin
      coin    = (m_owner == 1) ? int'(c1) : int'(c0);
      abort_s = (m_owner == 1) ? int'(!r1 || x1) : int'(!r0 || x0);
      val     = (coin == 1) ? 5 : ((coin == 2) ? 10 : 0);
      err     = (coin == 3) ? 1 : 0;
      if (val > 0) begin
        m_credit += val;
        m_idle = 0;
        if (m_credit >= PRICE) begin
          m_phase = 1; m_chg = m_credit - PRICE;
        end else if (abort_s != 0) begin
          m_phase = 2; m_chg = m_credit;
        end
      end else begin
        m_idle++;
        if (abort_s != 0 || m_idle == TMO) begin
          if (m_credit == 0) m_busy = 0;
          else begin
            m_phase = 2; m_chg = m_credit;
          end
        end
      end
    end
    e.gnt0     = (m_busy == 1) && (m_owner == 0);
    e.gnt1     = (m_busy == 1) && (m_owner == 1);
    e.dispense = (m_phase == 1);
    e.change   = 2'(m_chg / 5);
    e.busy     = (m_busy == 1);
    e.coin_err = (err == 1);
  endtask

  // One clock: drive inputs, predict, queue prediction at the edge.
  task automatic step(input logic r0, input logic r1, input logic [1:0] c0,
                      input logic [1:0] c1, input logic x0, input logic x1);
    exp_t e;
    req0 = r0; req1 = r1; coin0 = c0; coin1 = c1; cancel0 = x0; cancel1 = x1;
    m_update(r0, r1, c0, c1, x0, x1, e);
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  // Reset pulse between edges; outputs must clear while reset is still low.
  task automatic do_reset();
    exp_t z;
    z = '0;
    @(negedge clk);
    #1 reset = 1'b0;
    #1 q.push_back(z);
    imm_tgl = ~imm_tgl;
    #1 reset = 1'b1;
    m_reset();
  endtask

  initial begin
    reset = 1'b0; imm_tgl = 1'b0;
    req0 = 1'b0; req1 = 1'b0; coin0 = 2'b00; coin1 = 2'b00;
    cancel0 = 1'b0; cancel1 = 1'b0;
    m_reset();
    #2;
    do_reset();

    // Basic 5 + nothing + 10 vend on channel 0.
    step(1, 0, 2'b00, 2'b00, 0, 0);
    step(1, 0, 2'b01, 2'b00, 0, 0);
    step(1, 0, 2'b00, 2'b00, 0, 0);
    step(1, 0, 2'b10, 2'b00, 0, 0);
    step(0, 0, 2'b00, 2'b00, 0, 0);
    step(0, 0, 2'b00, 2'b00, 0, 0);

    // Both requesting: alternating grants, each 10+10 with 5c change.
    do_reset();
    for (int s = 0; s < 3; s++) begin
      step(1, 1, 2'b00, 2'b00, 0, 0);
      step(1, 1, 2'b10, 2'b10, 0, 0);
      step(1, 1, 2'b10, 2'b10, 0, 0);
      step(1, 1, 2'b00, 2'b00, 0, 0);
    end
    step(0, 0, 2'b00, 2'b00, 0, 0);

    // Channel 1 inserts 10 then cancels; channel 0 noise must be ignored.
    step(0, 1, 2'($urandom_range(0, 3)), 2'b00, 1'($urandom_range(0, 1)), 0);
    step(0, 1, 2'($urandom_range(0, 3)), 2'b10, 1'($urandom_range(0, 1)), 0);
    step(0, 1, 2'($urandom_range(0, 3)), 2'b00, 1'($urandom_range(0, 1)), 1);
    step(0, 0, 2'($urandom_range(0, 3)), 2'b00, 0, 0);
    step(0, 0, 2'b00, 2'b00, 0, 0);

    // Timeout refund after 8 coin-less cycles with 5c held, then 7 + coin.
    step(1, 0, 2'b00, 2'b00, 0, 0);
    step(1, 0, 2'b01, 2'b00, 0, 0);
    for (int k = 0; k < TMO; k++) step(1, 0, 2'b00, 2'b00, 0, 0);
    step(0, 0, 2'b00, 2'b00, 0, 0);
    step(1, 0, 2'b00, 2'b00, 0, 0);
    step(1, 0, 2'b01, 2'b00, 0, 0);
    for (int k = 0; k < TMO - 1; k++) step(1, 0, 2'b00, 2'b00, 0, 0);
    step(1, 0, 2'b01, 2'b00, 0, 0);
    step(1, 0, 2'b01, 2'b00, 0, 0);
    step(0, 0, 2'b00, 2'b00, 0, 0);

    // Coin with cancel: 10+5 vends, 5+5 refunds 10.
    step(1, 0, 2'b00, 2'b00, 0, 0);
    step(1, 0, 2'b10, 2'b00, 0, 0);
    step(1, 0, 2'b01, 2'b00, 1, 0);
    step(0, 0, 2'b00, 2'b00, 0, 0);
    step(1, 0, 2'b00, 2'b00, 0, 0);
    step(1, 0, 2'b01, 2'b00, 0, 0);
    step(1, 0, 2'b01, 2'b00, 1, 0);
    step(0, 0, 2'b00, 2'b00, 0, 0);

    // Mid-session reset with 10c held, then an illegal coin.
    step(1, 0, 2'b00, 2'b00, 0, 0);
    step(1, 0, 2'b10, 2'b00, 0, 0);
    do_reset();
    step(1, 0, 2'b00, 2'b00, 0, 0);
    step(1, 0, 2'b11, 2'b00, 0, 0);
    step(1, 0, 2'b01, 2'b00, 0, 0);
    step(1, 0, 2'b10, 2'b00, 0, 0);
    step(0, 0, 2'b00, 2'b00, 0, 0);

    // Randomized traffic on both channels.
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
